// File: rtl/mmu_instr_port.sv
// Instruction-side memory port: turns core_s1 fetch requests into single-beat
// bus reads and handles misalignment, bus errors and fetch abandonment.

package core_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } mmu_instr_req_s;

  typedef struct packed {
    logic        ready;
    logic [31:0] instr;
  } mmu_instr_rsp_s;
endpackage

module mmu_instr_port
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  mmu_instr_req_s mmu_instr_req,
  output mmu_instr_rsp_s mmu_instr_rsp,
  output logic           instr_fault,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic [29:0]    mem_req_addr,
  input  logic           mem_rsp_valid,
  input  logic [31:0]    mem_rsp_data,
  input  logic           mem_rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_DROP
  } state_e;

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_lat_addr;
  logic        r_ready;
  logic [31:0] r_instr;
  logic        r_fault;
  logic        r_mem_req_valid;

  logic        w_live;
  logic        w_aligned;
  logic        w_latch;
  logic        w_ready_d;
  logic [31:0] w_instr_d;
  logic        w_fault_d;
  logic        w_mem_req_valid_d;

  // A fetch stays live only while core_s1 keeps presenting the latched address.
  assign w_live    = mmu_instr_req.valid && (mmu_instr_req.addr == r_lat_addr);
  assign w_aligned = (mmu_instr_req.addr[1:0] == 2'b00);
  assign w_latch   = (r_state == S_IDLE) && mmu_instr_req.valid && w_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mmu_instr_req.valid) begin
          w_next = w_aligned ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next = w_live ? S_WAIT : S_DROP;
        end
      end
      S_WAIT: begin
        // A response landing in the same cycle liveness is lost retires the read.
        if (!w_live) begin
          w_next = mem_rsp_valid ? S_IDLE : S_DROP;
        end else if (mem_rsp_valid) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      S_DROP: begin
        if (mem_rsp_valid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the transition and registered, so nothing is combinational.
  always_comb begin
    w_ready_d         = (w_next == S_RESP);
    w_mem_req_valid_d = (w_next == S_REQ);
    w_instr_d         = 32'h0;
    w_fault_d         = 1'b0;
    if ((r_state == S_IDLE) && mmu_instr_req.valid && !w_aligned) begin
      w_fault_d = 1'b1;
    end
    if ((r_state == S_WAIT) && w_live && mem_rsp_valid) begin
      w_fault_d = mem_rsp_err;
      w_instr_d = mem_rsp_err ? 32'h0 : mem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_addr      <= 32'h0;
      r_ready         <= 1'b0;
      r_instr         <= 32'h0;
      r_fault         <= 1'b0;
      r_mem_req_valid <= 1'b0;
    end else begin
      if (w_latch) begin
        r_lat_addr <= mmu_instr_req.addr;
      end
      r_ready         <= w_ready_d;
      r_instr         <= w_instr_d;
      r_fault         <= w_fault_d;
      r_mem_req_valid <= w_mem_req_valid_d;
    end
  end

  assign mmu_instr_rsp.ready = r_ready;
  assign mmu_instr_rsp.instr = r_instr;
  assign instr_fault         = r_fault;
  assign mem_req_valid       = r_mem_req_valid;
  assign mem_req_addr        = r_lat_addr[31:2];

endmodule

// File: tb/tb_mmu_instr_port.sv
// Self-checking bench for mmu_instr_port: table-driven fetches against a bus
// model and a response scoreboard, plus hand-written abandon and reset sequences.

module tb_mmu_instr_port;
  import core_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          readyWait;
    int          rspDelay;
    bit          err;
    logic [31:0] expInstr;
    bit          expFault;
    int          expLatency;
    int          expReqs;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    bit          fault;
    int          cycle;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  mmu_instr_req_s req;
  mmu_instr_rsp_s rsp;
  logic           instrFault;
  logic           memReqValid;
  logic           memReqReady;
  logic [29:0]    memReqAddr;
  logic           memRspValid;
  logic [31:0]    memRspData;
  logic           memRspErr;

  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  exp_t        sbQ[$];
  bit          respSeen;

  int          busReadyWait;
  int          busRspDelay;
  bit          busErr;
  logic [29:0] busExpWord;
  bit          busForceValid;
  logic [31:0] busForceData;
  bit          rspPending;
  int          rspCountdown;
  logic [29:0] rspAddr;
  int          reqCount;
  int          firstReqCycle;

  vec_t vecs[8];

  mmu_instr_port dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mmu_instr_req (req),
    .mmu_instr_rsp (rsp),
    .instr_fault   (instrFault),
    .mem_req_valid (memReqValid),
    .mem_req_ready (memReqReady),
    .mem_req_addr  (memReqAddr),
    .mem_rsp_valid (memRspValid),
    .mem_rsp_data  (memRspData),
    .mem_rsp_err   (memRspErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [29:0] w);
    if (w == 30'h40) return 32'h0000_0013;
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycleCount);
    end
  endtask

  task automatic failNow(input string name, input string msg);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s at cycle %0d", name, msg, cycleCount);
  endtask

  // Compares the response port against the scoreboard head whenever ready pulses.
  task automatic checkOutput();
    exp_t e;
    if (rsp.ready) begin
      respSeen = 1'b1;
      if (sbQ.size() == 0) begin
        failNow("unexpected_ready", $sformatf("instr=%0h fault=%0b with nothing expected", rsp.instr, instrFault));
      end else begin
        e = sbQ.pop_front();
        check("rsp_cycle", 64'(cycleCount), 64'(e.cycle));
        check("rsp_instr", 64'(rsp.instr), 64'(e.instr));
        check("rsp_fault", 64'(instrFault), 64'(e.fault));
      end
    end else begin
      check("idle_zero", {31'h0, instrFault, rsp.instr}, 64'h0);
    end
  endtask

  // Bus model: drives this cycle's response, then decides whether to accept a request.
  task automatic busModel();
    if (rspPending && rspCountdown == 0) begin
      memRspValid = 1'b1;
      memRspErr   = busErr;
      if (busErr) memRspData = 32'hDEAD_BEEF;
      else if (busForceValid) memRspData = busForceData;
      else memRspData = memWord(rspAddr);
      busForceValid = 1'b0;
      rspPending    = 1'b0;
    end else begin
      memRspValid = 1'b0;
      memRspErr   = 1'b0;
      memRspData  = 32'h0;
      if (rspPending) rspCountdown--;
    end
    if (memReqValid) begin
      if (firstReqCycle < 0) firstReqCycle = cycleCount;
      check("req_addr", 64'(memReqAddr), 64'(busExpWord));
      if (busReadyWait > 0) begin
        memReqReady = 1'b0;
        busReadyWait--;
      end else begin
        memReqReady  = 1'b1;
        rspPending   = 1'b1;
        rspCountdown = busRspDelay;
        rspAddr      = memReqAddr;
        reqCount++;
      end
    end else begin
      memReqReady = 1'b0;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    busModel();
  endtask

  task automatic busClear();
    rspPending    = 1'b0;
    busForceValid = 1'b0;
    busReadyWait  = 0;
    busRspDelay   = 0;
    busErr        = 1'b0;
    memReqReady   = 1'b0;
    memRspValid   = 1'b0;
    memRspData    = 32'h0;
    memRspErr     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int k;
    int waited;
    busReadyWait  = v.readyWait;
    busRspDelay   = v.rspDelay;
    busErr        = v.err;
    busExpWord    = v.addr[31:2];
    reqCount      = 0;
    firstReqCycle = -1;
    req.valid     = 1'b1;
    req.addr      = v.addr;
    k             = cycleCount;
    sbQ.push_back('{v.expInstr, v.expFault, k + v.expLatency});
    respSeen = 1'b0;
    waited   = 0;
    while (!respSeen && waited < 40) begin
      stepCycle();
      waited++;
    end
    if (!respSeen) begin
      failNow("fetch_timeout", $sformatf("no ready for addr %0h", v.addr));
      sbQ.delete();
    end
    stepCycle();
    req.valid = 1'b0;
    req.addr  = 32'h0;
    stepCycle();
    stepCycle();
    check("bus_req_count", 64'(reqCount), 64'(v.expReqs));
    if (v.expReqs > 0) check("bus_req_cycle", 64'(firstReqCycle), 64'(k + 1));
    else check("no_bus_req", 64'(firstReqCycle), 64'(-1));
    busErr = 1'b0;
  endtask

  initial begin
    int k;
    int waited;
    req.valid = 1'b0;
    req.addr  = 32'h0;
    busClear();
    busExpWord = 30'h0;

    vecs[0] = '{32'h0000_0100, 0, 0, 1'b0, 32'h0000_0013, 1'b0, 3, 1};
    vecs[1] = '{32'h0000_0100, 3, 0, 1'b0, 32'h0000_0013, 1'b0, 6, 1};
    vecs[2] = '{32'h0000_0102, 0, 0, 1'b0, 32'h0,         1'b1, 1, 0};
    vecs[3] = '{32'h0000_0204, 0, 0, 1'b1, 32'h0,         1'b1, 3, 1};
    vecs[4] = '{32'h0000_0300, 0, 2, 1'b0, memWord(30'hC0), 1'b0, 5, 1};
    vecs[5] = '{32'hFFFF_FFFC, 1, 1, 1'b0, memWord(30'h3FFF_FFFF), 1'b0, 5, 1};
    vecs[6] = '{32'h0000_0001, 0, 0, 1'b0, 32'h0,         1'b1, 1, 0};
    vecs[7] = '{32'h0000_0000, 0, 0, 1'b0, memWord(30'h0), 1'b0, 3, 1};

    stepCycle();
    stepCycle();
    check("reset_ready", 64'(rsp.ready), 64'h0);
    check("reset_req_valid", 64'(memReqValid), 64'h0);
    check("reset_req_addr", 64'(memReqAddr), 64'h0);
    rst_n = 1'b1;
    stepCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Redirect while the read is in flight: the old response is dropped first.
    busClear();
    reqCount = 0;
    busRspDelay   = 5;
    busForceValid = 1'b1;
    busForceData  = 32'hDEAD_BEEF;
    busExpWord    = 30'h40;
    req.valid = 1'b1;
    req.addr  = 32'h0000_0100;
    k = cycleCount;
    sbQ.push_back('{memWord(30'h80), 1'b0, k + 11});
    stepCycle();
    stepCycle();
    stepCycle();
    req.addr    = 32'h0000_0200;
    busExpWord  = 30'h80;
    busRspDelay = 0;
    for (int c = 4; c <= 12; c++) begin
      stepCycle();
      check($sformatf("redirect_req_c%0d", c), 64'(memReqValid), 64'(c == 9));
    end
    check("redirect_sb_empty", 64'(sbQ.size()), 64'h0);
    check("redirect_bus_reqs", 64'(reqCount), 64'h2);
    req.valid = 1'b0;
    stepCycle();
    stepCycle();

    // Response coinciding with withdrawal returns straight to IDLE.
    busClear();
    busRspDelay = 1;
    busExpWord  = 30'h40;
    req.valid = 1'b1;
    req.addr  = 32'h0000_0100;
    stepCycle();
    stepCycle();
    stepCycle();
    req.valid   = 1'b0;
    busRspDelay = 0;
    stepCycle();
    busExpWord = 30'h80;
    req.valid  = 1'b1;
    req.addr   = 32'h0000_0200;
    k = cycleCount;
    sbQ.push_back('{memWord(30'h80), 1'b0, k + 3});
    respSeen = 1'b0;
    waited   = 0;
    while (!respSeen && waited < 40) begin
      stepCycle();
      waited++;
    end
    if (!respSeen) begin
      failNow("coincide_timeout", "fetch after coincident drop never completed");
      sbQ.delete();
    end
    stepCycle();
    req.valid = 1'b0;
    stepCycle();
    stepCycle();

    // Asynchronous reset while waiting for read data.
    busClear();
    busRspDelay = 5;
    busExpWord  = 30'h40;
    req.valid = 1'b1;
    req.addr  = 32'h0000_0100;
    stepCycle();
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    #1;
    check("async_req_addr", 64'(memReqAddr), 64'h0);
    check("async_req_valid", 64'(memReqValid), 64'h0);
    check("async_rsp", {31'h0, instrFault, rsp.instr}, 64'h0);
    check("async_ready", 64'(rsp.ready), 64'h0);
    busClear();
    req.valid = 1'b0;
    req.addr  = 32'h0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    applyStimulus('{32'h0000_0000, 0, 0, 1'b0, memWord(30'h0), 1'b0, 3, 1});

    check("final_sb_empty", 64'(sbQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
